// File: rtl/dmem_arbiter_pkg.sv
// Types and sizing shared by the data-memory arbiter and its wait counter.
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, HI, LO, DONE} arb_state_e;
  typedef enum logic {OWN_CPU = 1'b0, OWN_EXT = 1'b1} owner_e;

  localparam int EXT_MAX_WAIT_DFLT = 8;
  localparam int WAIT_W = $clog2(EXT_MAX_WAIT_DFLT + 1);
endpackage

// File: rtl/types_pkg.sv
// Shared scalar types for the datapath.
package types_pkg;
  typedef logic [15:0] uword;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester, memory and status signals of the data-memory arbiter.
interface dmem_arbiter_if
  import types_pkg::*;
#(
  parameter int ADDR_W = 16
) ();
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  uword              cpu_wdata;
  logic              cpu_ack;
  logic              cpu_stall;
  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  uword              ext_wdata;
  logic              ext_ack;
  uword              rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic [7:0]        mem_rdata;
  logic              busy;
  logic              owner;
  logic              align_err;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    input  mem_rdata,
    output cpu_ack, cpu_stall, ext_ack, rdata,
    output mem_addr, mem_wdata, mem_we,
    output busy, owner, align_err
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ext_req, ext_we, ext_addr, ext_wdata,
    output mem_rdata,
    input  cpu_ack, cpu_stall, ext_ack, rdata,
    input  mem_addr, mem_wdata, mem_we,
    input  busy, owner, align_err
  );
endinterface

// File: rtl/dmem_arbiter_wait_counter.sv
// Saturating counter of cycles the ext requester has gone ungranted.
module arb_wait_counter #(
  parameter int MAX = 8,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);
  logic [W-1:0] cnt_q, cnt_d;

  assign sat_o = (cnt_q == W'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !sat_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Shares the byte-wide data memory between the stage-3 cpu port and the ext port,
// sequencing each big-endian 16-bit word as two byte cycles.
module dmem_arbiter
  import types_pkg::*;
  import dmem_arb_pkg::*;
#(
  parameter int EXT_MAX_WAIT = 8,
  parameter int ADDR_W       = 16
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(EXT_MAX_WAIT + 1);

  arb_state_e        state_q, state_d;
  owner_e            owner_q;
  logic              we_q;
  logic              align_q;
  logic [ADDR_W-1:0] addr_q;
  uword              wdata_q;
  uword              rdata_q;
  logic [7:0]        rhi_q;

  logic              grant_cpu, grant_ext, grant, ext_sat;
  logic [ADDR_W-1:0] req_addr;

  arb_wait_counter #(.MAX(EXT_MAX_WAIT), .W(CNT_W)) u_wait (
    .clk   (clk),
    .rst   (rst),
    .inc_i (bus.ext_req & ~grant_ext),
    .clr_i (grant_ext | ~bus.ext_req),
    .sat_o (ext_sat)
  );

  // cpu has priority unless ext has waited long enough to force its turn
  always_comb begin
    grant_cpu = 1'b0;
    grant_ext = 1'b0;
    state_d   = state_q;
    case (state_q)
      IDLE: begin
        if (bus.ext_req && ext_sat) begin
          grant_ext = 1'b1;
        end else if (bus.cpu_req) begin
          grant_cpu = 1'b1;
        end else if (bus.ext_req) begin
          grant_ext = 1'b1;
        end
        if (grant_cpu || grant_ext) state_d = HI;
      end
      HI:      state_d = LO;
      LO:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign grant    = grant_cpu | grant_ext;
  assign req_addr = grant_ext ? bus.ext_addr : bus.cpu_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_CPU;
      we_q    <= 1'b0;
      align_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rhi_q   <= '0;
    end else begin
      state_q <= state_d;
      align_q <= 1'b0;
      if (grant) begin
        we_q    <= grant_ext ? bus.ext_we : bus.cpu_we;
        addr_q  <= {req_addr[ADDR_W-1:1], 1'b0};
        wdata_q <= grant_ext ? bus.ext_wdata : bus.cpu_wdata;
        owner_q <= grant_ext ? OWN_EXT : OWN_CPU;
        align_q <= req_addr[0];
      end
      if (state_q == LO && !we_q) rhi_q <= bus.mem_rdata;
      if (state_q == DONE && !we_q) rdata_q <= {rhi_q, bus.mem_rdata};
    end
  end

  // Memory strobes come only from registered state so no request input reaches mem_we
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    case (state_q)
      HI: begin
        bus.mem_addr  = addr_q;
        bus.mem_we    = we_q;
        bus.mem_wdata = we_q ? wdata_q[15:8] : 8'h00;
      end
      LO: begin
        bus.mem_addr  = addr_q | ADDR_W'(1);
        bus.mem_we    = we_q;
        bus.mem_wdata = we_q ? wdata_q[7:0] : 8'h00;
      end
      default: ;
    endcase
  end

  // Low read byte arrives in DONE itself, so it bypasses straight to rdata
  assign bus.rdata     = (state_q == DONE && !we_q) ? {rhi_q, bus.mem_rdata} : rdata_q;
  assign bus.cpu_ack   = (state_q == DONE) && (owner_q == OWN_CPU);
  assign bus.ext_ack   = (state_q == DONE) && (owner_q == OWN_EXT);
  assign bus.cpu_stall = bus.cpu_req & ~bus.cpu_ack;
  assign bus.busy      = (state_q != IDLE);
  assign bus.owner     = (owner_q == OWN_EXT);
  assign bus.align_err = align_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a transaction-level model.
module tb_dmem_arbiter;
  import types_pkg::*;

  localparam int MAXW = 8;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          gap;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(16)) ifc ();

  dmem_arbiter #(.EXT_MAX_WAIT(MAXW), .ADDR_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];

  always @(posedge clk) begin
    if (ifc.mem_we) mem[ifc.mem_addr] <= ifc.mem_wdata;
    ifc.mem_rdata <= mem[ifc.mem_addr];
  end

  int   total = 0;
  int   bad   = 0;
  logic m_owner = 1'b0;
  int   m_wait  = 0;

  txn_t        cpu_q[$];
  txn_t        ext_q[$];
  int          cpu_ack_cyc[$];
  int          ext_ack_cyc[$];
  int          align_cyc[$];
  logic [15:0] rd_log[$];
  logic        own_log[$];

  task automatic preload(input logic [15:0] a, input logic [7:0] v);
    mem[a] <= v;
    ref_mem[a] = v;
  endtask

  task automatic clear_logs();
    cpu_ack_cyc.delete();
    ext_ack_cyc.delete();
    align_cyc.delete();
    rd_log.delete();
    own_log.delete();
  endtask

  // Runs queued requests through the DUT while the model predicts every cycle.
  // Entered and left just after a rising edge.
  task automatic run_engine(input int max_cycles);
    bit          cpu_act = 0, ext_act = 0;
    int          cpu_gl = -1, ext_gl = -1;
    txn_t        cpu_cur = '{1'b0, 16'h0, 16'h0, 0};
    txn_t        ext_cur = '{1'b0, 16'h0, 16'h0, 0};
    txn_t        t;
    bit          m_busy = 0, m_we = 0, m_align = 0;
    int          m_grant = -10, m_ack = -10;
    logic [15:0] m_rd = 16'h0;
    logic [15:0] a;
    bit          e_cack, e_eack, e_align, g_cpu, g_ext;
    clear_logs();
    for (int c = 0; ; c++) begin
      if (m_busy && c > m_ack) m_busy = 0;
      if (!cpu_act && !ext_act && cpu_q.size() == 0 && ext_q.size() == 0 && !m_busy) begin
        ifc.cpu_req = 1'b0;
        ifc.ext_req = 1'b0;
        break;
      end
      if (c >= max_cycles) begin
        total++; bad++;
        $display("FAIL engine_timeout got=%0d cycles required<%0d", c, max_cycles);
        cpu_q.delete(); ext_q.delete();
        ifc.cpu_req = 1'b0;
        ifc.ext_req = 1'b0;
        break;
      end
      if (!cpu_act && cpu_q.size() > 0) begin
        if (cpu_gl < 0) cpu_gl = cpu_q[0].gap;
        if (cpu_gl == 0) begin cpu_cur = cpu_q.pop_front(); cpu_act = 1; cpu_gl = -1; end
        else cpu_gl--;
      end
      if (!ext_act && ext_q.size() > 0) begin
        if (ext_gl < 0) ext_gl = ext_q[0].gap;
        if (ext_gl == 0) begin ext_cur = ext_q.pop_front(); ext_act = 1; ext_gl = -1; end
        else ext_gl--;
      end
      ifc.cpu_req = cpu_act; ifc.cpu_we = cpu_cur.we;
      ifc.cpu_addr = cpu_cur.addr; ifc.cpu_wdata = cpu_cur.wdata;
      ifc.ext_req = ext_act; ifc.ext_we = ext_cur.we;
      ifc.ext_addr = ext_cur.addr; ifc.ext_wdata = ext_cur.wdata;

      e_cack  = m_busy && c == m_ack && !m_owner;
      e_eack  = m_busy && c == m_ack && m_owner;
      e_align = m_busy && c == m_grant + 1 && m_align;

      @(negedge clk);
      total++;
      if (ifc.cpu_ack !== e_cack) begin
        bad++; $display("FAIL cpu_ack cyc=%0d got=%b required=%b", c, ifc.cpu_ack, e_cack);
      end
      total++;
      if (ifc.ext_ack !== e_eack) begin
        bad++; $display("FAIL ext_ack cyc=%0d got=%b required=%b", c, ifc.ext_ack, e_eack);
      end
      total++;
      if (ifc.busy !== m_busy) begin
        bad++; $display("FAIL busy cyc=%0d got=%b required=%b", c, ifc.busy, m_busy);
      end
      total++;
      if (ifc.cpu_stall !== (cpu_act && !e_cack)) begin
        bad++; $display("FAIL cpu_stall cyc=%0d got=%b required=%b", c, ifc.cpu_stall, cpu_act && !e_cack);
      end
      total++;
      if (ifc.owner !== m_owner) begin
        bad++; $display("FAIL owner cyc=%0d got=%b required=%b", c, ifc.owner, m_owner);
      end
      total++;
      if (ifc.align_err !== e_align) begin
        bad++; $display("FAIL align_err cyc=%0d got=%b required=%b", c, ifc.align_err, e_align);
      end
      if ((e_cack || e_eack) && !m_we) begin
        total++;
        if (ifc.rdata !== m_rd) begin
          bad++; $display("FAIL rdata cyc=%0d got=%h required=%h", c, ifc.rdata, m_rd);
        end
      end
      if (ifc.cpu_ack === 1'b1) begin cpu_ack_cyc.push_back(c); rd_log.push_back(ifc.rdata); own_log.push_back(ifc.owner); end
      if (ifc.ext_ack === 1'b1) begin ext_ack_cyc.push_back(c); rd_log.push_back(ifc.rdata); own_log.push_back(ifc.owner); end
      if (ifc.align_err === 1'b1) align_cyc.push_back(c);

      g_cpu = 0; g_ext = 0;
      if (!m_busy) begin
        if (ext_act && m_wait == MAXW) g_ext = 1;
        else if (cpu_act) g_cpu = 1;
        else if (ext_act) g_ext = 1;
      end
      if (g_cpu || g_ext) begin
        t = g_ext ? ext_cur : cpu_cur;
        m_busy = 1; m_grant = c; m_ack = c + 3;
        m_owner = g_ext; m_we = t.we; m_align = t.addr[0];
        a = {t.addr[15:1], 1'b0};
        if (t.we) begin
          ref_mem[a] = t.wdata[15:8];
          ref_mem[a | 16'd1] = t.wdata[7:0];
        end else begin
          m_rd = {ref_mem[a], ref_mem[a | 16'd1]};
        end
      end
      m_wait = (ext_act && !g_ext) ? ((m_wait < MAXW) ? m_wait + 1 : MAXW) : 0;

      if (ifc.cpu_ack === 1'b1 && cpu_act) cpu_act = 0;
      if (ifc.ext_ack === 1'b1 && ext_act) ext_act = 0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({ifc.busy, ifc.cpu_ack, ifc.ext_ack, ifc.mem_we, ifc.owner, ifc.align_err} !== 6'b0) begin
      bad++; $display("FAIL reset_flags got=%b required=000000",
        {ifc.busy, ifc.cpu_ack, ifc.ext_ack, ifc.mem_we, ifc.owner, ifc.align_err});
    end
    total++;
    if (ifc.mem_addr !== 16'h0 || ifc.mem_wdata !== 8'h0) begin
      bad++; $display("FAIL reset_mem got=%h/%h required=0000/00", ifc.mem_addr, ifc.mem_wdata);
    end
    total++;
    if (ifc.rdata !== 16'h0) begin
      bad++; $display("FAIL reset_rdata got=%h required=0000", ifc.rdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    m_owner = 1'b0; m_wait = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_cpu_read();
    preload(16'h0000, 8'h2B);
    preload(16'h0001, 8'hCD);
    cpu_q.push_back('{1'b0, 16'h0000, 16'h0000, 0});
    run_engine(50);
    total++;
    if (cpu_ack_cyc.size() != 1 || cpu_ack_cyc[0] != 3) begin
      bad++; $display("FAIL read_latency got=%0d acks first=%0d required=1 at 3", cpu_ack_cyc.size(),
        cpu_ack_cyc.size() > 0 ? cpu_ack_cyc[0] : -1);
    end
    total++;
    if (rd_log.size() != 1 || rd_log[0] !== 16'h2BCD) begin
      bad++; $display("FAIL read_data got=%h required=2bcd", rd_log.size() > 0 ? rd_log[0] : 16'hxxxx);
    end
  endtask

  task automatic test_ext_write();
    ext_q.push_back('{1'b1, 16'h0002, 16'h579A, 0});
    run_engine(50);
    total++;
    if (ext_ack_cyc.size() != 1 || ext_ack_cyc[0] != 3 || cpu_ack_cyc.size() != 0) begin
      bad++; $display("FAIL ext_write_ack got ext=%0d cpu_acks=%0d required ext=3 cpu_acks=0",
        ext_ack_cyc.size() > 0 ? ext_ack_cyc[0] : -1, cpu_ack_cyc.size());
    end
    total++;
    if (mem[16'h0002] !== 8'h57 || mem[16'h0003] !== 8'h9A) begin
      bad++; $display("FAIL ext_write_mem got=%h%h required=579a", mem[16'h0002], mem[16'h0003]);
    end
  endtask

  task automatic test_contention();
    cpu_q.push_back('{1'b0, 16'h0000, 16'h0000, 0});
    ext_q.push_back('{1'b1, 16'h0010, 16'h1111, 0});
    run_engine(50);
    total++;
    if (cpu_ack_cyc.size() != 1 || cpu_ack_cyc[0] != 3 || ext_ack_cyc.size() != 1 || ext_ack_cyc[0] != 7) begin
      bad++; $display("FAIL contention_acks got cpu=%0d ext=%0d required cpu=3 ext=7",
        cpu_ack_cyc.size() > 0 ? cpu_ack_cyc[0] : -1, ext_ack_cyc.size() > 0 ? ext_ack_cyc[0] : -1);
    end
    total++;
    if (own_log.size() != 2 || own_log[0] !== 1'b0 || own_log[1] !== 1'b1) begin
      bad++; $display("FAIL contention_owner got=%0d entries required=0 then 1", own_log.size());
    end
    total++;
    if (mem[16'h0010] !== 8'h11 || mem[16'h0011] !== 8'h11) begin
      bad++; $display("FAIL contention_mem got=%h%h required=1111", mem[16'h0010], mem[16'h0011]);
    end
  endtask

  task automatic test_starvation();
    for (int i = 0; i < 4; i++) cpu_q.push_back('{1'b0, 16'h0020 + 16'(2 * i), 16'h0, 0});
    ext_q.push_back('{1'b1, 16'h0030, 16'hC3A5, 0});
    run_engine(100);
    total++;
    if (ext_ack_cyc.size() != 1 || ext_ack_cyc[0] != 11) begin
      bad++; $display("FAIL starve_ext got=%0d required=11", ext_ack_cyc.size() > 0 ? ext_ack_cyc[0] : -1);
    end
    total++;
    if (cpu_ack_cyc.size() != 4 || cpu_ack_cyc[0] != 3 || cpu_ack_cyc[1] != 7 ||
        cpu_ack_cyc[2] != 15 || cpu_ack_cyc[3] != 19) begin
      bad++; $display("FAIL starve_cpu got %0d acks, third=%0d required 3,7,15,19",
        cpu_ack_cyc.size(), cpu_ack_cyc.size() > 2 ? cpu_ack_cyc[2] : -1);
    end
  endtask

  task automatic test_align_wrap();
    cpu_q.push_back('{1'b1, 16'h0003, 16'hBEEF, 0});
    cpu_q.push_back('{1'b1, 16'hFFFF, 16'hA55A, 0});
    run_engine(50);
    total++;
    if (align_cyc.size() != 2 || align_cyc[0] != 1 || align_cyc[1] != 5) begin
      bad++; $display("FAIL align_pulse got %0d pulses first=%0d required 1,5",
        align_cyc.size(), align_cyc.size() > 0 ? align_cyc[0] : -1);
    end
    total++;
    if (mem[16'h0002] !== 8'hBE || mem[16'h0003] !== 8'hEF) begin
      bad++; $display("FAIL align_mem got=%h%h required=beef", mem[16'h0002], mem[16'h0003]);
    end
    total++;
    if (mem[16'hFFFE] !== 8'hA5 || mem[16'hFFFF] !== 8'h5A || mem[16'h0000] !== 8'h2B) begin
      bad++; $display("FAIL wrap_mem got=%h%h m0=%h required=a55a m0=2b",
        mem[16'hFFFE], mem[16'hFFFF], mem[16'h0000]);
    end
  endtask

  task automatic test_reset_mid();
    bit ack_seen = 0;
    preload(16'h0004, 8'h00);
    preload(16'h0005, 8'h00);
    ifc.cpu_req = 1'b1; ifc.cpu_we = 1'b1;
    ifc.cpu_addr = 16'h0004; ifc.cpu_wdata = 16'h1234;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    total++;
    if ({ifc.busy, ifc.cpu_ack, ifc.ext_ack, ifc.mem_we, ifc.owner, ifc.align_err} !== 6'b0 ||
        ifc.mem_addr !== 16'h0 || ifc.mem_wdata !== 8'h0 || ifc.rdata !== 16'h0) begin
      bad++; $display("FAIL midreset_outputs got flags=%b addr=%h rdata=%h required all zero",
        {ifc.busy, ifc.cpu_ack, ifc.ext_ack, ifc.mem_we, ifc.owner, ifc.align_err}, ifc.mem_addr, ifc.rdata);
    end
    ifc.cpu_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ifc.cpu_ack === 1'b1) ack_seen = 1;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    m_owner = 1'b0; m_wait = 0;
    @(negedge clk);
    if (ifc.cpu_ack === 1'b1) ack_seen = 1;
    total++;
    if (ack_seen) begin
      bad++; $display("FAIL midreset_ack got=1 required=0");
    end
    total++;
    if (mem[16'h0004] !== 8'h12 || mem[16'h0005] !== 8'h00) begin
      bad++; $display("FAIL midreset_mem got=%h%h required=1200", mem[16'h0004], mem[16'h0005]);
    end
    ref_mem[16'h0004] = 8'h12;
    @(posedge clk); #1;
    cpu_q.push_back('{1'b0, 16'h0004, 16'h0, 0});
    run_engine(50);
    total++;
    if (cpu_ack_cyc.size() != 1 || cpu_ack_cyc[0] != 3 || rd_log[0] !== 16'h1200) begin
      bad++; $display("FAIL after_reset_read got=%h required=1200 at cycle 3",
        rd_log.size() > 0 ? rd_log[0] : 16'hxxxx);
    end
  endtask

  task automatic test_random();
    int diffs = 0;
    logic [15:0] base;
    for (int i = 0; i < 80; i++) begin
      txn_t t;
      base = ($urandom_range(0, 3) == 0) ? 16'hFFF0 : 16'h0100;
      t.we    = 1'($urandom_range(0, 1));
      t.addr  = base | 16'($urandom_range(0, 15));
      t.wdata = 16'($urandom);
      t.gap   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
      if (i % 2 == 0) cpu_q.push_back(t);
      else ext_q.push_back(t);
    end
    run_engine(3000);
    total++;
    if (cpu_ack_cyc.size() != 40 || ext_ack_cyc.size() != 40) begin
      bad++; $display("FAIL random_ack_count got cpu=%0d ext=%0d required 40/40",
        cpu_ack_cyc.size(), ext_ack_cyc.size());
    end
    for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) diffs++;
    total++;
    if (diffs != 0) begin
      bad++; $display("FAIL random_mem got=%0d differing bytes required=0", diffs);
    end
  endtask

  initial begin
    ifc.cpu_req = 1'b0; ifc.cpu_we = 1'b0; ifc.cpu_addr = '0; ifc.cpu_wdata = '0;
    ifc.ext_req = 1'b0; ifc.ext_we = 1'b0; ifc.ext_addr = '0; ifc.ext_wdata = '0;
    for (int i = 0; i < 65536; i++) begin
      mem[i] <= 8'h00;
      ref_mem[i] = 8'h00;
    end
    test_reset();
    test_cpu_read();
    test_ext_write();
    test_contention();
    test_starvation();
    test_align_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
